adc3ph_spi_capture: RTL and testbench

- Upstream acquisition stage of the sequence decomposer.
- Reads one 14-bit two's-complement sample per phase (A, B, C) from a 3-channel serial ADC over a mode-0 SPI link.
- Presents the three samples together with a one-cycle valid strobe.
- Each output feeds a 14-bit signed-to-12-bit magnitude converter in the decomposer datapath.

---
 rtl/adc3ph_spi_capture_if.sv | 25 ++
 rtl/adc3ph_spi_capture.sv | 155 +++++++++++++++
 tb/tb_adc3ph_spi_capture.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/adc3ph_spi_capture_if.sv
// Signal bundle between the three-phase ADC capture block and its neighbours:
// capture request/result handshake plus the SPI pins toward the ADC.
interface adc3ph_spi_capture_if;
  logic        start;
  logic        adc_miso;
  logic        adc_sclk;
  logic        adc_cs_n;
  logic        adc_mosi;
  logic        busy;
  logic [13:0] data_a;
  logic [13:0] data_b;
  logic [13:0] data_c;
  logic        valid;
  logic        overrun;

  modport master (
    output start, adc_miso,
    input  adc_sclk, adc_cs_n, adc_mosi, busy, data_a, data_b, data_c, valid, overrun
  );

  modport slave (
    input  start, adc_miso,
    output adc_sclk, adc_cs_n, adc_mosi, busy, data_a, data_b, data_c, valid, overrun
  );
endinterface

// File: rtl/adc3ph_spi_capture.sv
// Reads one 14-bit sample per phase (A, B, C) from a 3-channel SPI ADC (mode 0)
// and presents the set together with a single-cycle valid strobe.
module adc3ph_spi_capture #(
  parameter int CLK_DIV = 4,
  parameter int GAP_CYC = 8
) (
  input logic                 clk,
  input logic                 rst,
  adc3ph_spi_capture_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);

  state_t      state;
  state_t      next_state;
  logic [7:0]  div_cnt;
  logic [4:0]  half_cnt;
  logic [1:0]  ch;
  logic        sclk;
  logic [13:0] shreg;
  logic [13:0] hold_a;
  logic [13:0] hold_b;
  logic [13:0] data_a;
  logic [13:0] data_b;
  logic [13:0] data_c;
  logic        busy;
  logic        valid;
  logic        overrun;
  logic        div_done;
  logic        gap_done;
  logic        frame_done;
  logic        accept;

  assign div_done   = (div_cnt == DIV_LAST);
  assign gap_done   = (div_cnt == GAP_LAST);
  assign frame_done = (state == SHIFT) && div_done && (half_cnt == 5'd31);
  // busy lags the return to IDLE by one cycle, so a start in that cycle is refused
  assign accept     = (state == IDLE) && bus.start && !busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (accept) next_state = SETUP;
      SETUP: if (div_done) next_state = SHIFT;
      SHIFT: if (frame_done) next_state = GAP;
      GAP:   if (gap_done) next_state = (ch == 2'd2) ? IDLE : SETUP;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      half_cnt <= '0;
      ch       <= '0;
      sclk     <= 1'b0;
      shreg    <= '0;
      hold_a   <= '0;
      hold_b   <= '0;
      data_a   <= '0;
      data_b   <= '0;
      data_c   <= '0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      valid   <= 1'b0;
      overrun <= bus.start && busy;
      busy    <= (state != IDLE) || (next_state != IDLE);

      if ((state != next_state) || ((state == SHIFT) && div_done)) begin
        div_cnt <= '0;
      end else if (state != IDLE) begin
        div_cnt <= div_cnt + 8'd1;
      end

      // MISO is sampled on the same system edge that raises SCLK
      if (state == SHIFT) begin
        if (div_done) begin
          sclk     <= ~sclk;
          half_cnt <= half_cnt + 5'd1;
          if (!sclk) begin
            shreg <= {shreg[12:0], bus.adc_miso};
          end
        end
      end else begin
        sclk     <= 1'b0;
        half_cnt <= '0;
      end

      if (accept) begin
        ch <= '0;
      end else if ((state == GAP) && gap_done && (ch != 2'd2)) begin
        ch <= ch + 2'd1;
      end

      if (frame_done) begin
        unique case (ch)
          2'd0: hold_a <= shreg;
          2'd1: hold_b <= shreg;
          default: begin
            data_a <= hold_a;
            data_b <= hold_b;
            data_c <= shreg;
            valid  <= 1'b1;
          end
        endcase
      end
    end
  end

  // Bit 1 (ch[1]) covers SETUP and the first SCLK period; bit 2 (ch[0]) the second
  always_comb begin
    bus.adc_sclk = sclk;
    bus.adc_cs_n = 1'b1;
    bus.adc_mosi = 1'b0;
    unique case (state)
      SETUP: begin
        bus.adc_cs_n = 1'b0;
        bus.adc_mosi = ch[1];
      end
      SHIFT: begin
        bus.adc_cs_n = 1'b0;
        if (half_cnt < 5'd2) begin
          bus.adc_mosi = ch[1];
        end else if (half_cnt < 5'd4) begin
          bus.adc_mosi = ch[0];
        end
      end
      default: begin
        bus.adc_cs_n = 1'b1;
        bus.adc_mosi = 1'b0;
      end
    endcase
  end

  assign bus.busy    = busy;
  assign bus.valid   = valid;
  assign bus.overrun = overrun;
  assign bus.data_a  = data_a;
  assign bus.data_b  = data_b;
  assign bus.data_c  = data_c;

endmodule

// File: tb/tb_adc3ph_spi_capture.sv
// Directed bench for adc3ph_spi_capture: a behavioural 3-channel ADC answers each
// frame, and a monitor logs strobes, SCLK edges and chip-select windows per instance.
module tb_adc3ph_spi_capture;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   check_count = 0;
  int   error_count = 0;
  int   clear_seq = 0;
  int   seen_seq = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc3ph_spi_capture_if bus0 ();
  adc3ph_spi_capture_if bus1 ();

  adc3ph_spi_capture dut0 (.clk(clk), .rst(rst), .bus(bus0));
  adc3ph_spi_capture #(.CLK_DIV(2), .GAP_CYC(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic [1:0] sclk_w, cs_w, mosi_w, valid_w, ovr_w, busy_w;
  logic [1:0] miso_r = 2'b00;
  assign sclk_w  = {bus1.adc_sclk, bus0.adc_sclk};
  assign cs_w    = {bus1.adc_cs_n, bus0.adc_cs_n};
  assign mosi_w  = {bus1.adc_mosi, bus0.adc_mosi};
  assign valid_w = {bus1.valid, bus0.valid};
  assign ovr_w   = {bus1.overrun, bus0.overrun};
  assign busy_w  = {bus1.busy, bus0.busy};
  assign bus0.adc_miso = miso_r[0];
  assign bus1.adc_miso = miso_r[1];

  logic [13:0] sample_val [2][3];

  logic [1:0] prev_c = 2'b11;
  logic [1:0] prev_s = 2'b00;
  int   frame_rise [2];
  logic [1:0] addr_r [2];
  int   rise_cnt [2], mosi_err [2], last_rise [2], min_iv [2], max_iv [2];
  int   valid_cnt [2], valid_cyc [2], ovr_cnt [2], busy_last [2];
  int   ovr_cyc [2][4];
  int   n_low [2], n_gap [2], n_addr [2], cur_low [2], cur_high [2];
  int   low_len [2][8], gap_len [2][8], addr_log [2][8];

  // ADC model and monitor: runs on the falling system edge, away from DUT updates
  always @(negedge clk) begin
    int b;
    if (clear_seq != seen_seq) begin
      seen_seq = clear_seq;
      for (int k = 0; k < 2; k++) begin
        rise_cnt[k] = 0; mosi_err[k] = 0; last_rise[k] = 0;
        min_iv[k] = 1000000; max_iv[k] = 0;
        valid_cnt[k] = 0; valid_cyc[k] = -1; ovr_cnt[k] = 0; busy_last[k] = -1;
        n_low[k] = 0; n_gap[k] = 0; n_addr[k] = 0; cur_low[k] = 0; cur_high[k] = 0;
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (valid_w[k]) begin
        valid_cnt[k]++;
        valid_cyc[k] = cyc;
      end
      if (ovr_w[k]) begin
        if (ovr_cnt[k] < 4) ovr_cyc[k][ovr_cnt[k]] = cyc;
        ovr_cnt[k]++;
      end
      if (busy_w[k]) busy_last[k] = cyc;
      if (!cs_w[k]) begin
        if (prev_c[k]) begin
          if (n_low[k] > 0 && n_gap[k] < 8) begin
            gap_len[k][n_gap[k]] = cur_high[k];
            n_gap[k]++;
          end
          frame_rise[k] = 0;
          addr_r[k] = 2'd0;
          miso_r[k] = 1'b1;
        end
        cur_low[k]++;
        if (sclk_w[k] && !prev_s[k]) begin
          rise_cnt[k]++;
          frame_rise[k]++;
          if (frame_rise[k] > 1) begin
            if (cyc - last_rise[k] < min_iv[k]) min_iv[k] = cyc - last_rise[k];
            if (cyc - last_rise[k] > max_iv[k]) max_iv[k] = cyc - last_rise[k];
          end
          last_rise[k] = cyc;
          if (frame_rise[k] == 1) begin
            addr_r[k][1] = mosi_w[k];
          end else if (frame_rise[k] == 2) begin
            addr_r[k][0] = mosi_w[k];
            if (n_addr[k] < 8) addr_log[k][n_addr[k]] = int'(addr_r[k]);
            n_addr[k]++;
          end else if (mosi_w[k] !== 1'b0) begin
            mosi_err[k]++;
          end
        end
        if (!sclk_w[k] && prev_s[k]) begin
          b = frame_rise[k] + 1;
          if (b <= 2) miso_r[k] = 1'b1;
          else if (b <= 16 && addr_r[k] != 2'd3) miso_r[k] = sample_val[k][addr_r[k]][16 - b];
          else miso_r[k] = 1'b0;
        end
      end else begin
        if (!prev_c[k]) begin
          if (n_low[k] < 8) low_len[k][n_low[k]] = cur_low[k];
          n_low[k]++;
          cur_low[k] = 0;
          cur_high[k] = 0;
        end
        cur_high[k]++;
      end
      prev_c[k] = cs_w[k];
      prev_s[k] = sclk_w[k];
    end
  end

  task automatic checkOutput(input string tag, input logic signed [31:0] actual,
                             input logic signed [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic goToCycle(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input int k);
    if (k == 0) bus0.start = 1'b1;
    else bus1.start = 1'b1;
    @(posedge clk);
    #1;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
  endtask

  initial begin
    int t0;
    int t1;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 3; j++) sample_val[k][j] = 14'h0000;
    clear_seq = 1;
    @(posedge clk);
    #1;
    goToCycle(3);
    rst = 1'b0;
    goToCycle(23);

    $display("[TB] reset and idle");
    checkOutput("rst_cs_n", bus0.adc_cs_n, 1);
    checkOutput("rst_sclk", bus0.adc_sclk, 0);
    checkOutput("rst_mosi", bus0.adc_mosi, 0);
    checkOutput("rst_busy", bus0.busy, 0);
    checkOutput("rst_valid", bus0.valid, 0);
    checkOutput("rst_data_a", bus0.data_a, 0);
    checkOutput("rst_data_b", bus0.data_b, 0);
    checkOutput("rst_data_c", bus0.data_c, 0);
    checkOutput("rst_cs_n_div2", bus1.adc_cs_n, 1);

    $display("[TB] full capture, default timing, with overrun pulses");
    sample_val[0][0] = 14'h1FFF;
    sample_val[0][1] = 14'h2000;
    sample_val[0][2] = 14'h3FFF;
    clear_seq++;
    t0 = cyc;
    applyStimulus(0);
    checkOutput("busy_after_start", bus0.busy, 1);
    checkOutput("cs_n_after_start", bus0.adc_cs_n, 0);
    goToCycle(t0 + 200);
    applyStimulus(0);
    goToCycle(t0 + 421);
    checkOutput("busy_at_421", bus0.busy, 1);
    applyStimulus(0);
    checkOutput("busy_at_422", bus0.busy, 0);
    checkOutput("cs_n_at_422", bus0.adc_cs_n, 1);
    goToCycle(t0 + 430);
    checkOutput("valid_count", valid_cnt[0], 1);
    checkOutput("valid_cycle", valid_cyc[0] - t0, 413);
    checkOutput("data_a", $signed(bus0.data_a), 8191);
    checkOutput("data_b", $signed(bus0.data_b), -8192);
    checkOutput("data_c", $signed(bus0.data_c), -1);
    checkOutput("sclk_rises", rise_cnt[0], 48);
    checkOutput("cs_windows", n_low[0], 3);
    for (int i = 0; i < 3; i++) checkOutput($sformatf("cs_low_len%0d", i), low_len[0][i], 132);
    checkOutput("gap_count", n_gap[0], 2);
    for (int i = 0; i < 2; i++) checkOutput($sformatf("gap_len%0d", i), gap_len[0][i], 8);
    checkOutput("addr_frames", n_addr[0], 3);
    for (int i = 0; i < 3; i++) checkOutput($sformatf("mosi_addr%0d", i), addr_log[0][i], i);
    checkOutput("mosi_data_bits", mosi_err[0], 0);
    checkOutput("overrun_count", ovr_cnt[0], 2);
    checkOutput("overrun_cyc0", ovr_cyc[0][0] - t0, 201);
    checkOutput("overrun_cyc1", ovr_cyc[0][1] - t0, 422);
    checkOutput("busy_last_cycle", busy_last[0] - t0, 421);

    $display("[TB] reset mid-frame, then fresh capture");
    sample_val[0][0] = 14'h0ABC;
    sample_val[0][1] = 14'h1234;
    sample_val[0][2] = 14'h3210;
    clear_seq++;
    t0 = cyc;
    applyStimulus(0);
    goToCycle(t0 + 250);
    rst = 1'b1;
    goToCycle(t0 + 251);
    rst = 1'b0;
    checkOutput("abort_cs_n", bus0.adc_cs_n, 1);
    checkOutput("abort_sclk", bus0.adc_sclk, 0);
    checkOutput("abort_busy", bus0.busy, 0);
    checkOutput("abort_data_a", bus0.data_a, 0);
    goToCycle(t0 + 260);
    checkOutput("abort_no_valid", valid_cnt[0], 0);
    clear_seq++;
    t1 = cyc;
    applyStimulus(0);
    goToCycle(t1 + 420);
    checkOutput("fresh_valid_count", valid_cnt[0], 1);
    checkOutput("fresh_valid_cycle", valid_cyc[0] - t1, 413);
    checkOutput("fresh_data_a", bus0.data_a, 14'h0ABC);
    checkOutput("fresh_data_b", bus0.data_b, 14'h1234);
    checkOutput("fresh_data_c", bus0.data_c, 14'h3210);

    $display("[TB] fastest timing instance");
    sample_val[1][0] = 14'h0001;
    sample_val[1][1] = 14'h1555;
    sample_val[1][2] = 14'h2AAA;
    clear_seq++;
    t0 = cyc;
    applyStimulus(1);
    goToCycle(t0 + 210);
    checkOutput("div2_valid_count", valid_cnt[1], 1);
    checkOutput("div2_valid_cycle", valid_cyc[1] - t0, 201);
    checkOutput("div2_data_a", bus1.data_a, 14'h0001);
    checkOutput("div2_data_b", bus1.data_b, 14'h1555);
    checkOutput("div2_data_c", bus1.data_c, 14'h2AAA);
    checkOutput("div2_sclk_rises", rise_cnt[1], 48);
    checkOutput("div2_period_min", min_iv[1], 4);
    checkOutput("div2_period_max", max_iv[1], 4);
    checkOutput("div2_cs_low_len", low_len[1][0], 66);
    checkOutput("div2_gap_len", gap_len[1][0], 1);
    checkOutput("div2_busy_last", busy_last[1] - t0, 202);
    checkOutput("div2_mosi_data_bits", mosi_err[1], 0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
